// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch FIFO of {pc, inst} drained by decode, flushed on redirect.
// Optional perf counters (perf_fetched, perf_stall) are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
`ifdef FETCH_PERF_CNT_EN
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`else
    input  logic [31:0] redirect_pc
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [31:0]   pc;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Handshake: the head transfers on any cycle with out_valid && out_ready,
    // except that a redirect in the same cycle discards it instead.
    assign push      = (count != FULL) && !redirect_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_valid = (count != '0);
    assign imem_pc   = pc;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]   : 32'd0;
    assign out_inst  = out_valid ? inst_mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= 32'd0;
                inst_mem[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= pc;
                inst_mem[wr_ptr] <= imem_inst;
                wr_ptr           <= wr_ptr + 1'b1;
                pc               <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model feeds an expected queue; a negedge monitor compares.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;
`ifdef FETCH_PERF_CNT_EN
    localparam int W = 161;
`else
    localparam int W = 97;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  m_q[$];
    logic [31:0]  m_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  m_fetched;
    logic [31:0]  m_stall;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_pc       (imem_pc),
        .imem_inst     (imem_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .redirect_valid(redirect_valid),
`ifdef FETCH_PERF_CNT_EN
        .redirect_pc   (redirect_pc),
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`else
        .redirect_pc   (redirect_pc)
`endif
    );

    // Clock and combinational instruction memory.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_inst = imem_pc ^ XOR_KEY;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs, advance the reference model, push the expected post-edge view.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic         can_push;
        logic [31:0]  head;
        logic [W-1:0] e;
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (r) begin
            m_q.delete();
            m_pc = RESET_PC;
`ifdef FETCH_PERF_CNT_EN
            m_fetched = 32'd0;
            m_stall   = 32'd0;
`endif
        end else begin
`ifdef FETCH_PERF_CNT_EN
            if (m_q.size() != 0 && !rdy) m_stall = m_stall + 32'd1;
`endif
            if (rv) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                can_push = (m_q.size() < DEPTH);
                if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
                if (can_push) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
                    m_fetched = m_fetched + 32'd1;
`endif
                end
            end
        end
        head = (m_q.size() != 0) ? m_q[0] : 32'd0;
        e[96]    = (m_q.size() != 0);
        e[95:64] = head;
        e[63:32] = (m_q.size() != 0) ? (head ^ XOR_KEY) : 32'd0;
        e[31:0]  = m_pc;
`ifdef FETCH_PERF_CNT_EN
        e[160:129] = m_fetched;
        e[128:97]  = m_stall;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected snapshot per clock, compared away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_valid", {31'd0, out_valid}, {31'd0, e[96]});
            check("out_pc",    out_pc,    e[95:64]);
            check("out_inst",  out_inst,  e[63:32]);
            check("imem_pc",   imem_pc,   e[31:0]);
`ifdef FETCH_PERF_CNT_EN
            check("perf_fetched", perf_fetched, e[160:129]);
            check("perf_stall",   perf_stall,   e[128:97]);
`endif
        end
    end

    initial begin
        logic rv;
        logic rst;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;

        // Reset then streaming.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check("reset_imem_pc", imem_pc, RESET_PC);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("stream_first_pc", out_pc, 32'h0000_0000);
        check("stream_first_inst", out_inst, 32'hA5A5_0000);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Backpressure after reset.
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("bp_imem_pc_hold", imem_pc, 32'h0000_0010);
        check("bp_out_pc", out_pc, 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
        check("bp_perf_stall", perf_stall, 32'd9);
        check("bp_perf_fetched", perf_fetched, 32'd4);
`endif
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect with a full FIFO.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0203, 1'b0);
        check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("redir_target_pc", out_pc, 32'h0000_0200);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_next_pc", out_pc, 32'h0000_0204);

        // Redirect and pop in the same cycle.
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        check("redir_pop_valid", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("redir_pop_pc", out_pc, 32'h0000_0040);

        // PC wrap.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_pc2", out_pc, 32'h0000_0000);

        // Randomized traffic, including mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            cycle(rst, rv, $urandom(), 1'($urandom_range(0, 2) != 0));
        end

        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (3) @(negedge clk);
        check("expected_queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
